// File: rtl/decode_stage.sv
// RV32I decode stage: splits an instruction into register indices, immediate, ALU op and
// control strobes, held in a valid/ready pipeline register. Optional M-extension via DECODE_M_EXT_EN.
module decode_stage #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ALU_OP_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4:0]          rs1,
   output logic [4:0]          rs2,
   output logic [4:0]          rd,
   output logic [XLEN-1:0]     immediate,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                alu_src_imm,
   output logic                limit_immediate,
   output logic                reg_write,
   output logic                mem_read,
   output logic                mem_write,
   output logic                branch,
   output logic                jump,
   output logic [2:0]          mem_size,
   output logic                illegal,
   output logic                illegal_seen
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_XOR   = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(4);
   localparam logic [ALU_OP_W-1:0] ALU_SLL   = ALU_OP_W'(5);
   localparam logic [ALU_OP_W-1:0] ALU_SRL   = ALU_OP_W'(6);
   localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(7);
   localparam logic [ALU_OP_W-1:0] ALU_SLTU  = ALU_OP_W'(8);
   localparam logic [ALU_OP_W-1:0] ALU_SRA   = ALU_OP_W'(9);
   localparam logic [ALU_OP_W-1:0] ALU_PASSB = ALU_OP_W'(10);
`ifdef DECODE_M_EXT_EN
   localparam logic [6:0] F7_MULDIV = 7'b0000001;
   localparam logic [ALU_OP_W-1:0] ALU_MUL    = ALU_OP_W'(11);
   localparam logic [ALU_OP_W-1:0] ALU_MULH   = ALU_OP_W'(12);
   localparam logic [ALU_OP_W-1:0] ALU_MULHSU = ALU_OP_W'(13);
   localparam logic [ALU_OP_W-1:0] ALU_MULHU  = ALU_OP_W'(14);
`endif

   // Base integer funct3 -> ALU op (funct7 alternates handled by the caller)
   function automatic logic [ALU_OP_W-1:0] f3_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  f3_alu = ALU_ADD;
         3'b001:  f3_alu = ALU_SLL;
         3'b010:  f3_alu = ALU_SLT;
         3'b011:  f3_alu = ALU_SLTU;
         3'b100:  f3_alu = ALU_XOR;
         3'b101:  f3_alu = ALU_SRL;
         3'b110:  f3_alu = ALU_OR;
         default: f3_alu = ALU_AND;
      endcase
   endfunction

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opc = in_instr[6:0];
   assign f3  = in_instr[14:12];
   assign f7  = in_instr[31:25];

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   logic [XLEN-1:0]     imm_d,  imm_q;
   logic [ALU_OP_W-1:0] alu_d,  alu_q;
   logic [4:0]          rs1_q, rs2_q, rd_d, rd_q;
   logic [2:0]          msize_d, msize_q;
   logic src_d, src_q, lim_d, lim_q, rw_d, rw_q, mr_d, mr_q, mw_d, mw_q;
   logic br_d, br_q, jmp_d, jmp_q, ill_d, ill_q;
   logic [31:0] imm32;
   logic valid_q, seen_q, xfer;

   // Instruction decode into the next bundle
   always_comb begin
      ill_d   = 1'b0;
      alu_d   = ALU_ADD;
      src_d   = 1'b0;
      lim_d   = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      br_d    = 1'b0;
      jmp_d   = 1'b0;
      msize_d = 3'b000;
      imm32   = 32'h0;
      case (opc)
         OPC_OP: begin
            rw_d = 1'b1;
            if (f7 == F7_BASE)                        alu_d = f3_alu(f3);
            else if (f7 == F7_ALT && f3 == 3'b000)    alu_d = ALU_SUB;
            else if (f7 == F7_ALT && f3 == 3'b101)    alu_d = ALU_SRA;
`ifdef DECODE_M_EXT_EN
            else if (f7 == F7_MULDIV && !f3[2]) begin
               case (f3[1:0])
                  2'b00:   alu_d = ALU_MUL;
                  2'b01:   alu_d = ALU_MULH;
                  2'b10:   alu_d = ALU_MULHSU;
                  default: alu_d = ALU_MULHU;
               endcase
            end
`endif
            else                                      ill_d = 1'b1;
         end
         OPC_OPIMM: begin
            rw_d  = 1'b1;
            src_d = 1'b1;
            imm32 = imm_i;
            alu_d = f3_alu(f3);
            if (f3 == 3'b001) begin
               lim_d = 1'b1;
               if (f7 != F7_BASE) ill_d = 1'b1;
            end else if (f3 == 3'b101) begin
               lim_d = 1'b1;
               if (f7 == F7_ALT)       alu_d = ALU_SRA;
               else if (f7 != F7_BASE) ill_d = 1'b1;
            end
         end
         OPC_LOAD: begin
            src_d   = 1'b1;
            mr_d    = 1'b1;
            rw_d    = 1'b1;
            msize_d = f3;
            imm32   = imm_i;
         end
         OPC_STORE: begin
            src_d   = 1'b1;
            mw_d    = 1'b1;
            msize_d = f3;
            imm32   = imm_s;
         end
         OPC_BRANCH: begin
            alu_d = ALU_SUB;
            br_d  = 1'b1;
            imm32 = imm_b;
         end
         OPC_LUI: begin
            alu_d = ALU_PASSB;
            src_d = 1'b1;
            rw_d  = 1'b1;
            imm32 = imm_u;
         end
         OPC_AUIPC: begin
            src_d = 1'b1;
            rw_d  = 1'b1;
            imm32 = imm_u;
         end
         OPC_JAL: begin
            src_d = 1'b1;
            rw_d  = 1'b1;
            jmp_d = 1'b1;
            imm32 = imm_j;
         end
         OPC_JALR: begin
            src_d = 1'b1;
            rw_d  = 1'b1;
            jmp_d = 1'b1;
            imm32 = imm_i;
         end
         default: ill_d = 1'b1;
      endcase
      // Unsupported encodings carry no side effects and no decoded fields
      if (ill_d) begin
         alu_d   = ALU_ADD;
         src_d   = 1'b0;
         lim_d   = 1'b0;
         rw_d    = 1'b0;
         mr_d    = 1'b0;
         mw_d    = 1'b0;
         br_d    = 1'b0;
         jmp_d   = 1'b0;
         msize_d = 3'b000;
         imm32   = 32'h0;
      end
   end

   assign rd_d  = rw_d ? in_instr[11:7] : 5'd0;
   assign imm_d = XLEN'($signed(imm32));

   assign in_ready = !valid_q || out_ready;
   assign xfer     = in_valid && in_ready;

   // Pipeline register; flush discards both the held and the incoming bundle
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         seen_q  <= 1'b0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         src_q   <= 1'b0;
         lim_q   <= 1'b0;
         rw_q    <= 1'b0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         br_q    <= 1'b0;
         jmp_q   <= 1'b0;
         msize_q <= '0;
         ill_q   <= 1'b0;
      end else begin
         if (valid_q && out_ready && ill_q) seen_q <= 1'b1;
         if (flush)                         valid_q <= 1'b0;
         else if (xfer)                     valid_q <= 1'b1;
         else if (valid_q && out_ready)     valid_q <= 1'b0;
         if (xfer && !flush) begin
            rs1_q   <= in_instr[19:15];
            rs2_q   <= in_instr[24:20];
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            src_q   <= src_d;
            lim_q   <= lim_d;
            rw_q    <= rw_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            br_q    <= br_d;
            jmp_q   <= jmp_d;
            msize_q <= msize_d;
            ill_q   <= ill_d;
         end
      end
   end

   assign out_valid       = valid_q;
   assign illegal_seen    = seen_q;
   assign rs1             = rs1_q;
   assign rs2             = rs2_q;
   assign rd              = rd_q;
   assign immediate       = imm_q;
   assign alu_op          = alu_q;
   assign alu_src_imm     = src_q;
   assign limit_immediate = lim_q;
   assign reg_write       = rw_q;
   assign mem_read        = mr_q;
   assign mem_write       = mw_q;
   assign branch          = br_q;
   assign jump            = jmp_q;
   assign mem_size        = msize_q;
   assign illegal         = ill_q;

endmodule
